// File: rtl/li_delay_fifo_pkg.sv
// li_delay_fifo_pkg: sizing helpers shared by the latency-insensitive channel library
package li_delay_fifo_pkg;

    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Top bit index of a payload bus; a width-0 control channel still carries one bit.
    function automatic int safe_hi(input int width);
        return (width == 0) ? 0 : width - 1;
    endfunction

endpackage

// File: rtl/li_delay_fifo_if.sv
// li_delay_fifo_if: VALID/CONSUMED token channel into and out of li_delay_fifo
interface li_delay_fifo_if
    import li_delay_fifo_pkg::*;
#(
    parameter int width = 1
);
    logic [safe_hi(width):0] IN_WRITE;
    logic                    IN_WRITE_VALID;
    logic                    IN_WRITE_CONSUMED;
    logic                    IN_EN_WRITE;
    logic                    IN_EN_WRITE_VALID;
    logic                    IN_EN_WRITE_CONSUMED;
    logic [safe_hi(width):0] OUT_READ;
    logic                    OUT_EN_READ;
    logic                    OUT_READ_VALID;
    logic                    OUT_READ_CONSUMED;

    modport master (
        output IN_WRITE, IN_WRITE_VALID, IN_EN_WRITE, IN_EN_WRITE_VALID, OUT_READ_CONSUMED,
        input  IN_WRITE_CONSUMED, IN_EN_WRITE_CONSUMED, OUT_READ, OUT_EN_READ, OUT_READ_VALID
    );

    modport slave (
        input  IN_WRITE, IN_WRITE_VALID, IN_EN_WRITE, IN_EN_WRITE_VALID, OUT_READ_CONSUMED,
        output IN_WRITE_CONSUMED, IN_EN_WRITE_CONSUMED, OUT_READ, OUT_EN_READ, OUT_READ_VALID
    );

endinterface

// File: rtl/li_delay_fifo.sv
// li_delay_fifo: latency-insensitive token FIFO preloaded with init_count tokens to model an N-cycle delay
module li_delay_fifo
    import li_delay_fifo_pkg::*;
#(
    parameter int width      = 1,
    parameter int depth      = 4,
    parameter int init       = 0,
    parameter int init_count = 1
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    li_delay_fifo_if.slave             ch,
    output logic [clog2(depth+1)-1:0]  COUNT
);
    localparam int DW = safe_hi(width) + 1;
    localparam int CW = clog2(depth + 1);
    localparam int PW = (depth > 1) ? clog2(depth) : 1;
    localparam logic [PW-1:0] LAST = PW'(depth - 1);

    logic [DW:0]   mem [depth];
    logic [PW-1:0] head, tail;
    logic          inp_valid, full, empty, enq, deq;

    // Full blocks enq even when a deq happens the same cycle, so CONSUMED never depends on OUT_READ_CONSUMED.
    always_comb begin
        full                    = COUNT == CW'(depth);
        empty                   = COUNT == '0;
        inp_valid               = (width == 0 || ch.IN_WRITE_VALID) && ch.IN_EN_WRITE_VALID;
        enq                     = inp_valid && !full;
        deq                     = !empty && (width == 0 || ch.OUT_READ_CONSUMED);
        ch.IN_WRITE_CONSUMED    = inp_valid ? !full : 1'b1;
        ch.IN_EN_WRITE_CONSUMED = inp_valid ? !full : 1'b1;
        ch.OUT_READ             = mem[head][DW-1:0];
        ch.OUT_EN_READ          = mem[head][DW];
        ch.OUT_READ_VALID       = !empty;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            head  <= '0;
            tail  <= PW'(init_count % depth);
            COUNT <= CW'(init_count);
            for (int i = 0; i < depth; i++) mem[i] <= (i < init_count) ? {1'b1, DW'(init)} : '0;
        end else begin
            if (enq) begin
                mem[tail] <= {ch.IN_EN_WRITE, ch.IN_WRITE};
                tail      <= (tail == LAST) ? '0 : tail + 1'b1;
            end
            if (deq) head <= (head == LAST) ? '0 : head + 1'b1;
            if (enq != deq) COUNT <= enq ? COUNT + 1'b1 : COUNT - 1'b1;
        end
    end

endmodule

// File: tb/tb_li_delay_fifo.sv
// tb_li_delay_fifo: four configurations checked every cycle against a queue model, plus directed scenarios
module tb_li_delay_fifo;
    localparam int N = 4;
    localparam int W[N] = '{8, 8, 8, 0};
    localparam int D[N] = '{4, 4, 3, 5};
    localparam int I[N] = '{5, 0, 0, 0};
    localparam int C[N] = '{2, 0, 1, 2};

    logic       CLK = 1'b0;
    logic       rst_n = 1'b0;
    logic       armed = 1'b0;
    logic       wv [N] = '{default: 1'b0};
    logic       ev [N] = '{default: 1'b0};
    logic       en [N] = '{default: 1'b0};
    logic       rc [N] = '{default: 1'b0};
    logic [7:0] wd [N] = '{default: 8'h0};
    logic       o_valid [N];
    logic       o_en [N];
    logic       o_cons [N];
    logic       o_econs [N];
    logic [7:0] o_data [N];
    int         o_cnt [N];
    int         checks = 0;
    int         fails = 0;

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    for (genvar g = 0; g < N; g++) begin : u
        localparam int DW = (W[g] == 0) ? 1 : W[g];
        logic [li_delay_fifo_pkg::clog2(D[g]+1)-1:0] cnt;
        logic [8:0] q [$];
        logic [8:0] h;
        logic       c_iv, c_full;
        logic       m_iv, m_enq, m_deq;

        li_delay_fifo_if #(.width(W[g])) bus ();

        li_delay_fifo #(.width(W[g]), .depth(D[g]), .init(I[g]), .init_count(C[g])) dut (
            .CLK(CLK), .RST_N(rst_n), .ch(bus.slave), .COUNT(cnt)
        );

        assign bus.IN_WRITE          = wd[g][DW-1:0];
        assign bus.IN_WRITE_VALID    = wv[g];
        assign bus.IN_EN_WRITE       = en[g];
        assign bus.IN_EN_WRITE_VALID = ev[g];
        assign bus.OUT_READ_CONSUMED = rc[g];
        assign o_valid[g]            = bus.OUT_READ_VALID;
        assign o_en[g]               = bus.OUT_EN_READ;
        assign o_cons[g]             = bus.IN_WRITE_CONSUMED;
        assign o_econs[g]            = bus.IN_EN_WRITE_CONSUMED;
        assign o_data[g]             = 8'(bus.OUT_READ);
        assign o_cnt[g]              = int'(cnt);

        // Reference: a bounded queue of {en,data} tokens.
        always @(posedge CLK) begin
            if (!rst_n) begin
                q.delete();
                for (int i = 0; i < C[g]; i++) q.push_back({1'b1, 8'(I[g])});
            end else begin
                m_iv  = (W[g] == 0 || wv[g]) && ev[g];
                m_enq = m_iv && q.size() < D[g];
                m_deq = q.size() > 0 && (W[g] == 0 || rc[g]);
                if (m_deq) void'(q.pop_front());
                if (m_enq) q.push_back({en[g], wd[g]});
            end
        end

        always @(negedge CLK) begin
            if (armed) begin
                c_full = q.size() == D[g];
                c_iv   = (W[g] == 0 || wv[g]) && ev[g];
                chk($sformatf("u%0d_valid", g), o_valid[g], q.size() != 0);
                chk($sformatf("u%0d_count", g), o_cnt[g], q.size());
                chk($sformatf("u%0d_wcons", g), o_cons[g], c_iv ? !c_full : 1'b1);
                chk($sformatf("u%0d_econs", g), o_econs[g], c_iv ? !c_full : 1'b1);
                if (q.size() != 0) begin
                    h = q[0];
                    chk($sformatf("u%0d_en", g), o_en[g], h[8]);
                    chk($sformatf("u%0d_data", g), o_data[g], 8'(h[DW-1:0]));
                end
            end
        end
    end

    initial begin
        cyc();
        armed = 1'b1;
        cyc();
        rst_n = 1'b1;
        // reset state of depth=4, init_count=2, init=5, then drain
        chk("t1_valid", o_valid[0], 1);
        chk("t1_data0", o_data[0], 5);
        chk("t1_en0", o_en[0], 1);
        chk("t1_count", o_cnt[0], 2);
        rc[0] = 1'b1;
        cyc();
        chk("t1_data1", o_data[0], 5);
        chk("t1_count1", o_cnt[0], 1);
        cyc();
        chk("t1_empty", o_valid[0], 0);
        chk("t1_count0", o_cnt[0], 0);
        rc[0] = 1'b0;
        // depth=3 streaming enq&deq across pointer wrap
        rc[2] = 1'b1; wv[2] = 1'b1; ev[2] = 1'b1; en[2] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            wd[2] = 8'(k);
            cyc();
            chk("t4_data", o_data[2], k);
            chk("t4_count", o_cnt[2], 1);
        end
        rc[2] = 1'b0; wv[2] = 1'b0; ev[2] = 1'b0;
        // fill to full with init_count=0, fifth write refused
        wv[1] = 1'b1; ev[1] = 1'b1; en[1] = 1'b1;
        for (int v = 1; v <= 5; v++) begin
            wd[1] = 8'(v);
            #1;
            chk("t2_cons", o_cons[1], v <= 4);
            cyc();
        end
        chk("t2_count", o_cnt[1], 4);
        rc[1] = 1'b1;
        for (int v = 1; v <= 5; v++) begin
            if (v == 3) begin wv[1] = 1'b0; ev[1] = 1'b0; end
            #1;
            chk("t2_order", o_data[1], v);
            cyc();
        end
        chk("t2_drained", o_valid[1], 0);
        rc[1] = 1'b0;
        // full with a simultaneous deq: enq waits one cycle
        wv[0] = 1'b1; ev[0] = 1'b1; en[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wd[0] = 8'(10 + k);
            cyc();
        end
        chk("t3_full", o_cnt[0], 4);
        wd[0] = 8'd14; rc[0] = 1'b1;
        #1;
        chk("t3_blocked", o_cons[0], 0);
        cyc();
        chk("t3_count3", o_cnt[0], 3);
        chk("t3_head", o_data[0], 11);
        rc[0] = 1'b0;
        #1;
        chk("t3_accept", o_cons[0], 1);
        cyc();
        chk("t3_count4", o_cnt[0], 4);
        wv[0] = 1'b0; ev[0] = 1'b0; rc[0] = 1'b1;
        for (int k = 11; k <= 14; k++) begin
            chk("t3_order", o_data[0], k);
            cyc();
        end
        chk("t3_empty", o_valid[0], 0);
        rc[0] = 1'b0;
        // payload valid without enable token: nothing taken; then a bubble token
        wv[1] = 1'b1; ev[1] = 1'b0; wd[1] = 8'h33;
        #1;
        chk("t5_cons_idle", o_cons[1], 1);
        cyc();
        chk("t5_none", o_cnt[1], 0);
        ev[1] = 1'b1; en[1] = 1'b0; wd[1] = 8'h77;
        cyc();
        wv[1] = 1'b0; ev[1] = 1'b0;
        chk("t5_valid", o_valid[1], 1);
        chk("t5_bubble", o_en[1], 0);
        chk("t5_data", o_data[1], 8'h77);
        rc[1] = 1'b1;
        cyc();
        chk("t5_gone", o_valid[1], 0);
        rc[1] = 1'b0;
        // width=0 channel: tokens in flight, then reset restores init_count
        ev[3] = 1'b1;
        cyc();
        cyc();
        chk("t6_pre", o_cnt[3], 1);
        rst_n = 1'b0;
        cyc();
        chk("t6_count", o_cnt[3], 2);
        chk("t6_valid", o_valid[3], 1);
        rst_n = 1'b1; ev[3] = 1'b0;
        // random traffic with occasional mid-run resets
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < N; k++) begin
                wv[k] = $urandom_range(0, 9) < 8;
                ev[k] = $urandom_range(0, 9) < 8;
                en[k] = $urandom_range(0, 3) != 0;
                rc[k] = $urandom_range(0, 9) < 6;
                wd[k] = 8'($urandom);
            end
            rst_n = $urandom_range(0, 199) != 0;
            cyc();
        end
        rst_n = 1'b1;
        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
